// File: rtl/btn_event_scheduler_pkg.sv
// Shared types and helpers for the button event scheduler.
// Holds the repeat-FSM state encoding and a lowest-set-bit search.
package btn_event_scheduler_pkg;

  localparam int unsigned MAX_BTN = 8;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } r_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int unsigned lowest_set(input logic [MAX_BTN-1:0] v);
    logic [MAX_BTN-1:0] sh;
    int unsigned        idx;
    logic               found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_BTN; i++) begin
      sh = v >> i;
      if (!found && sh[0]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_event_scheduler_tick_gen.sv
// Free-running timebase divider: TICK pulses for one cycle every TICK_DIV cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0] tcnt_d;
  logic             wrap_c;

  always_comb begin
    wrap_c = (tcnt_q == CNT_W'(TICK_DIV - 1));
    tcnt_d = wrap_c ? '0 : tcnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign TICK = wrap_c;

endmodule

// File: rtl/btn_event_scheduler.sv
// Merges debounced press pulses and hold-to-repeat events into one
// round-robin arbitrated valid/ready command stream.
module btn_event_scheduler #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned REPEAT_DLY = 500,
  parameter int unsigned REPEAT_PER = 100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] PULSE,
  input  logic [N_BTN-1:0] LEVEL,
  input  logic             CMD_READY,
  output logic             CMD_VALID,
  output logic [ID_W-1:0]  CMD_ID,
  output logic             CMD_REPEAT,
  output logic [N_BTN-1:0] PEND,
  output logic             OVF
);

  import btn_event_scheduler_pkg::*;

  logic tick_c;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick_c)
  );

  // First requester after 'last', wrapping modulo N_BTN.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                              input logic [ID_W-1:0]  last);
    logic [N_BTN-1:0] sh;
    logic [ID_W-1:0]  pick;
    logic             found;
    int unsigned      idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      idx = (32'(last) + k) % N_BTN;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  r_state_e         state_q, state_d;
  logic [ID_W-1:0]  own_q, own_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [N_BTN-1:0] lvl_sh_c;
  logic             level_own_c;
  logic             rep_fire_c;

  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  logic             ovf_q, ovf_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
  logic             cmd_repeat_q, cmd_repeat_d;
  logic [ID_W-1:0]  last_q, last_d;

  logic             arb_free_c;
  logic             arb_go_c;
  logic [ID_W-1:0]  win_c;
  logic [N_BTN-1:0] rep_sh_c;
  logic [N_BTN-1:0] set_c;
  logic [N_BTN-1:0] grant_c;

  always_comb begin
    lvl_sh_c    = LEVEL >> own_q;
    level_own_c = lvl_sh_c[0];
  end

  // Repeat FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= R_IDLE;
      own_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Repeat FSM: next state; a fresh press always takes ownership
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    rcnt_d  = rcnt_q;
    if (PULSE != '0) begin
      own_d   = ID_W'(lowest_set(MAX_BTN'(PULSE)));
      rcnt_d  = CNT_W'(REPEAT_DLY);
      state_d = R_DELAY;
    end else if (state_q != R_IDLE) begin
      if (!level_own_c) begin
        state_d = R_IDLE;
      end else if (tick_c) begin
        if (rcnt_q == CNT_W'(1)) begin
          rcnt_d  = CNT_W'(REPEAT_PER);
          state_d = R_REPEAT;
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Repeat FSM: outputs
  always_comb begin
    rep_fire_c = 1'b0;
    if (PULSE == '0 && state_q != R_IDLE && level_own_c && tick_c &&
        rcnt_q == CNT_W'(1)) begin
      rep_fire_c = 1'b1;
    end
  end

  always_comb begin
    arb_free_c = !cmd_valid_q || CMD_READY;
    arb_go_c   = arb_free_c && (pend_q != '0);
    win_c      = rr_pick(pend_q, last_q);
    rep_sh_c   = rep_q >> win_c;
    for (int i = 0; i < N_BTN; i++) begin
      set_c[i]   = PULSE[i] || (rep_fire_c && own_q == ID_W'(i));
      grant_c[i] = arb_go_c && (win_c == ID_W'(i));
    end
  end

  // Pending flags: an event on a still-pending, ungranted button is lost
  always_comb begin
    pend_d = pend_q;
    rep_d  = rep_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (set_c[i]) begin
        if (pend_q[i] && !grant_c[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          rep_d[i]  = !PULSE[i];
        end
      end else if (grant_c[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    cmd_repeat_d = cmd_repeat_q;
    last_d       = last_q;
    if (arb_go_c) begin
      cmd_valid_d  = 1'b1;
      cmd_id_d     = win_c;
      cmd_repeat_d = rep_sh_c[0];
      last_d       = win_c;
    end else if (arb_free_c) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q       <= '0;
      rep_q        <= '0;
      ovf_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      cmd_repeat_q <= 1'b0;
      last_q       <= ID_W'(N_BTN - 1);
    end else begin
      pend_q       <= pend_d;
      rep_q        <= rep_d;
      ovf_q        <= ovf_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      cmd_repeat_q <= cmd_repeat_d;
      last_q       <= last_d;
    end
  end

  assign CMD_VALID  = cmd_valid_q;
  assign CMD_ID     = cmd_id_q;
  assign CMD_REPEAT = cmd_repeat_q;
  assign PEND       = pend_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed self-checking bench for btn_event_scheduler with a fast timebase.
module tb_btn_event_scheduler;

  logic       CLK;
  logic       RST;
  logic [3:0] PULSE;
  logic [3:0] LEVEL;
  logic       CMD_READY;
  logic       CMD_VALID;
  logic [1:0] CMD_ID;
  logic       CMD_REPEAT;
  logic [3:0] PEND;
  logic       OVF;

  int total;
  int bad;

  btn_event_scheduler #(
    .N_BTN      (4),
    .ID_W       (2),
    .TICK_DIV   (4),
    .REPEAT_DLY (3),
    .REPEAT_PER (2),
    .CNT_W      (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PULSE      (PULSE),
    .LEVEL      (LEVEL),
    .CMD_READY  (CMD_READY),
    .CMD_VALID  (CMD_VALID),
    .CMD_ID     (CMD_ID),
    .CMD_REPEAT (CMD_REPEAT),
    .PEND       (PEND),
    .OVF        (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change at negedge; one reset edge leaves the tick counter at 0.
  task automatic do_reset();
    RST       = 1'b1;
    PULSE     = 4'b0000;
    LEVEL     = 4'b0000;
    CMD_READY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (CMD_VALID !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", CMD_VALID); end
    total++; if (CMD_ID !== 2'd0)     begin bad++; $display("FAIL reset_id got=%0d exp=0", CMD_ID); end
    total++; if (CMD_REPEAT !== 1'b0) begin bad++; $display("FAIL reset_repeat got=%b exp=0", CMD_REPEAT); end
    total++; if (PEND !== 4'b0000)    begin bad++; $display("FAIL reset_pend got=%b exp=0000", PEND); end
    total++; if (OVF !== 1'b0)        begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
  endtask

  task automatic test_single_press();
    logic exp_v;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      PULSE = (k == 10) ? 4'b0001 : 4'b0000;
      LEVEL = (k == 10) ? 4'b0001 : 4'b0000;
      @(negedge CLK);
      exp_v = (k == 11);
      total++;
      if (CMD_VALID !== exp_v) begin
        bad++; $display("FAIL single_valid edge=%0d got=%b exp=%b", k, CMD_VALID, exp_v);
      end
      if (exp_v) begin
        total++;
        if (CMD_ID !== 2'd0 || CMD_REPEAT !== 1'b0) begin
          bad++; $display("FAIL single_cmd got id=%0d rep=%b exp id=0 rep=0", CMD_ID, CMD_REPEAT);
        end
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic exp_v;
    logic exp_r;
    int   ncmd;
    do_reset();
    ncmd = 0;
    for (int k = 1; k <= 50; k++) begin
      PULSE = (k == 1) ? 4'b0100 : 4'b0000;
      LEVEL = (k <= 40) ? 4'b0100 : 4'b0000;
      @(negedge CLK);
      exp_v = (k == 2) || (k == 13) || (k == 21) || (k == 29) || (k == 37);
      exp_r = (k != 2);
      total++;
      if (CMD_VALID !== exp_v) begin
        bad++; $display("FAIL hold_valid edge=%0d got=%b exp=%b", k, CMD_VALID, exp_v);
      end
      if (CMD_VALID === 1'b1) ncmd++;
      if (exp_v) begin
        total++;
        if (CMD_ID !== 2'd2 || CMD_REPEAT !== exp_r) begin
          bad++; $display("FAIL hold_cmd edge=%0d got id=%0d rep=%b exp id=2 rep=%b", k, CMD_ID, CMD_REPEAT, exp_r);
        end
      end
    end
    total++; if (ncmd != 5) begin bad++; $display("FAIL hold_count got=%0d exp=5", ncmd); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    CMD_READY = 1'b0;
    PULSE     = 4'b1111;
    @(negedge CLK);
    total++; if (PEND !== 4'b1111 || CMD_VALID !== 1'b0) begin
      bad++; $display("FAIL b2b_set got pend=%b v=%b exp pend=1111 v=0", PEND, CMD_VALID);
    end
    PULSE = 4'b0000;
    @(negedge CLK);
    total++; if (PEND !== 4'b1110 || CMD_VALID !== 1'b1 || CMD_ID !== 2'd0) begin
      bad++; $display("FAIL b2b_load got pend=%b v=%b id=%0d exp pend=1110 v=1 id=0", PEND, CMD_VALID, CMD_ID);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge CLK);
      total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'd0 || PEND !== 4'b1110) begin
        bad++; $display("FAIL b2b_hold got v=%b id=%0d pend=%b exp v=1 id=0 pend=1110", CMD_VALID, CMD_ID, PEND);
      end
    end
    CMD_READY = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge CLK);
      total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'(j) || CMD_REPEAT !== 1'b0) begin
        bad++; $display("FAIL b2b_seq got v=%b id=%0d rep=%b exp v=1 id=%0d rep=0", CMD_VALID, CMD_ID, CMD_REPEAT, j);
      end
    end
    @(negedge CLK);
    total++; if (CMD_VALID !== 1'b0 || PEND !== 4'b0000 || OVF !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got v=%b pend=%b ovf=%b exp v=0 pend=0000 ovf=0", CMD_VALID, PEND, OVF);
    end
  endtask

  task automatic test_overflow();
    int n_id1;
    do_reset();
    CMD_READY = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      PULSE = (k == 1) ? 4'b0001 : ((k == 3 || k == 6) ? 4'b0010 : 4'b0000);
      @(negedge CLK);
      if (k == 5) begin
        total++; if (OVF !== 1'b0 || PEND !== 4'b0010) begin
          bad++; $display("FAIL ovf_pre got ovf=%b pend=%b exp ovf=0 pend=0010", OVF, PEND);
        end
      end
    end
    total++; if (OVF !== 1'b1 || PEND !== 4'b0010 || CMD_ID !== 2'd0) begin
      bad++; $display("FAIL ovf_set got ovf=%b pend=%b id=%0d exp ovf=1 pend=0010 id=0", OVF, PEND, CMD_ID);
    end
    PULSE     = 4'b0000;
    CMD_READY = 1'b1;
    n_id1     = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (CMD_VALID === 1'b1 && CMD_ID === 2'd1) n_id1++;
    end
    total++; if (n_id1 != 1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", n_id1); end
    total++; if (OVF !== 1'b1 || CMD_VALID !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky got ovf=%b v=%b exp ovf=1 v=0", OVF, CMD_VALID);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    CMD_READY = 1'b0;
    PULSE     = 4'b0010;
    @(negedge CLK);
    PULSE = 4'b0000;
    @(negedge CLK);
    total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'd1) begin
      bad++; $display("FAIL rr_first got v=%b id=%0d exp v=1 id=1", CMD_VALID, CMD_ID);
    end
    PULSE = 4'b1001;
    @(negedge CLK);
    total++; if (PEND !== 4'b1001) begin bad++; $display("FAIL rr_pend got=%b exp=1001", PEND); end
    PULSE = 4'b0000;
    @(negedge CLK);
    CMD_READY = 1'b1;
    @(negedge CLK);
    total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'd3) begin
      bad++; $display("FAIL rr_wrap3 got v=%b id=%0d exp v=1 id=3", CMD_VALID, CMD_ID);
    end
    @(negedge CLK);
    total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'd0) begin
      bad++; $display("FAIL rr_wrap0 got v=%b id=%0d exp v=1 id=0", CMD_VALID, CMD_ID);
    end
    @(negedge CLK);
    total++; if (CMD_VALID !== 1'b0) begin bad++; $display("FAIL rr_idle got v=%b exp=0", CMD_VALID); end
  endtask

  task automatic test_reset_mid();
    int stray;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      PULSE     = (k == 1) ? 4'b0100 : 4'b0000;
      LEVEL     = 4'b0100;
      CMD_READY = (k < 13);
      @(negedge CLK);
    end
    total++; if (CMD_VALID !== 1'b1 || CMD_ID !== 2'd2 || CMD_REPEAT !== 1'b1) begin
      bad++; $display("FAIL mid_pre got v=%b id=%0d rep=%b exp v=1 id=2 rep=1", CMD_VALID, CMD_ID, CMD_REPEAT);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++; if (CMD_VALID !== 1'b0 || CMD_ID !== 2'd0 || CMD_REPEAT !== 1'b0 || PEND !== 4'b0000 || OVF !== 1'b0) begin
      bad++; $display("FAIL mid_rst got v=%b id=%0d rep=%b pend=%b ovf=%b exp all 0", CMD_VALID, CMD_ID, CMD_REPEAT, PEND, OVF);
    end
    CMD_READY = 1'b1;
    stray     = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (CMD_VALID !== 1'b0 || PEND !== 4'b0000) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL mid_norepeat got=%0d stray cycles exp=0", stray); end
    LEVEL = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_back_to_back();
    test_overflow();
    test_rr_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
